result_reader: RTL and testbench

RESULT_READER -- requirements
Module: result_reader

---
 rtl/result_reader.sv | 121 ++++++++++++
 tb/tb_result_reader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/result_reader.sv
// Result buffer (2**ADDRESSSIZE x DATASIZE) streamed out on start.
// Two cycles from start to first outValid, then one word per 2 cycles at best.
// outData/outLast hold in SEND until outReady; `RESULT_READER_ZSKIP_EN skips zero words.
module result_reader #(
  parameter int DATASIZE    = 32,
  parameter int ADDRESSSIZE = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wrEn,
  input  logic [ADDRESSSIZE-1:0] wrAddress,
  input  logic [DATASIZE-1:0]    wrData,
  input  logic                   start,
  input  logic [ADDRESSSIZE:0]   count,
  output logic                   outValid,
  input  logic                   outReady,
  output logic [DATASIZE-1:0]    outData,
  output logic                   outLast,
  output logic                   busy,
  output logic                   done
);

  localparam int DEPTH = 1 << ADDRESSSIZE;
  localparam logic [ADDRESSSIZE-1:0] ADDR_ONE = 1;
  localparam logic [ADDRESSSIZE:0]   CNT_ONE  = 1;

  typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

  state_t                 state_q, state_d;
  logic [ADDRESSSIZE-1:0] rd_addr_q, rd_addr_d;
  logic [ADDRESSSIZE:0]   cnt_q, cnt_d;
  logic [DATASIZE-1:0]    out_data_q, out_data_d;
  logic                   out_last_q, out_last_d;
  logic [DATASIZE-1:0]    mem_q [DEPTH];
  logic [DATASIZE-1:0]    mem_d [DEPTH];
  logic [DATASIZE-1:0]    rd_word;
  logic                   at_last;

  // Reads use mem_q, so a same-edge write to the fetched entry is not seen.
  always_comb begin
    mem_d = mem_q;
    if (wrEn) mem_d[wrAddress] = wrData;
  end

  always_comb begin
    rd_word    = mem_q[rd_addr_q];
    at_last    = ({1'b0, rd_addr_q} == (cnt_q - CNT_ONE));
    state_d    = state_q;
    rd_addr_d  = rd_addr_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (count != '0) begin
            cnt_d     = count;
            rd_addr_d = '0;
            state_d   = FETCH;
          end else begin
            state_d = DONE;
          end
        end
      end
      FETCH: begin
`ifdef RESULT_READER_ZSKIP_EN
        if (rd_word == '0) begin
          if (at_last) state_d = DONE;
          else         rd_addr_d = rd_addr_q + ADDR_ONE;
        end else begin
          out_data_d = rd_word;
          out_last_d = at_last;
          state_d    = SEND;
        end
`else
        out_data_d = rd_word;
        out_last_d = at_last;
        state_d    = SEND;
`endif
      end
      SEND: begin
        if (outReady) begin
          if (out_last_q) begin
            state_d = DONE;
          end else begin
            rd_addr_d = rd_addr_q + ADDR_ONE;
            state_d   = FETCH;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      rd_addr_q  <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      mem_q      <= mem_d;
    end
  end

  // outLast is qualified by SEND so a stale flag never leaks out.
  assign outValid = (state_q == SEND);
  assign outLast  = out_last_q && (state_q == SEND);
  assign outData  = out_data_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);

endmodule

// File: tb/tb_result_reader.sv
// Bench for result_reader: directed scenarios plus random streams against a queue model.
module tb_result_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        wrEn;
  logic [2:0]  wrAddress;
  logic [31:0] wrData;
  logic        start;
  logic [3:0]  count;
  logic        outValid;
  logic        outReady;
  logic [31:0] outData;
  logic        outLast;
  logic        busy;
  logic        done;

  result_reader dut (
    .clk(clk), .rst(rst), .wrEn(wrEn), .wrAddress(wrAddress), .wrData(wrData),
    .start(start), .count(count), .outValid(outValid), .outReady(outReady),
    .outData(outData), .outLast(outLast), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] model_mem [8];
  logic [31:0] exp_d [$];
  logic        exp_l [$];

  int n_vld, first_vld_cyc, done_cyc;
  int stall_first = 0;
  int rdy_pct = 100;
  int inj_cyc = -1;
  logic [2:0]  inj_addr;
  logic [31:0] inj_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [2:0] a, input logic [31:0] d);
    wrEn = 1'b1; wrAddress = a; wrData = d;
    tick();
    wrEn = 1'b0;
    model_mem[a] = d;
  endtask

  // Expected stream: entries 0..cnt-1 in order, last flag on entry cnt-1.
  task automatic build_exp(input int cnt);
    exp_d.delete();
    exp_l.delete();
    for (int i = 0; i < cnt; i++) begin
`ifdef RESULT_READER_ZSKIP_EN
      if (model_mem[i] == 32'h0) continue;
`endif
      exp_d.push_back(model_mem[i]);
      exp_l.push_back(i == cnt - 1);
    end
  endtask

  task automatic run_stream(input int cnt);
    int stall;
    logic holding;
    logic [31:0] held;
    logic rdy;
    stall = stall_first;
    holding = 1'b0;
    held = '0;
    start = 1'b1; count = 4'(cnt);
    tick();
    start = 1'b0;
    n_vld = 0; first_vld_cyc = -1; done_cyc = -1;
    for (int cyc = 0; cyc < 100 && done_cyc < 0; cyc++) begin
      wrEn = 1'b0;
      if (cyc == inj_cyc) begin
        wrEn = 1'b1; wrAddress = inj_addr; wrData = inj_data;
        model_mem[inj_addr] = inj_data;
      end
      chk("busy_in_stream", 64'(busy), 64'(1));
      if (done) begin
        done_cyc = cyc;
        chk("valid_at_done", 64'(outValid), 64'(0));
      end else if (outValid) begin
        n_vld++;
        if (first_vld_cyc < 0) first_vld_cyc = cyc;
        if (holding) chk("hold_data", 64'(outData), 64'(held));
        if (exp_d.size() == 0) begin
          chk("extra_word", 64'(exp_d.size()), 64'(1));
        end else begin
          chk("out_data", 64'(outData), 64'(exp_d[0]));
          chk("out_last", 64'(outLast), 64'(exp_l[0]));
          if (stall > 0) begin
            rdy = 1'b0;
            stall--;
          end else begin
            rdy = (int'($urandom_range(0, 99)) < rdy_pct);
          end
          outReady = rdy;
          if (rdy) begin
            void'(exp_d.pop_front());
            void'(exp_l.pop_front());
            holding = 1'b0;
          end else begin
            holding = 1'b1;
            held = outData;
          end
        end
      end else begin
        outReady = 1'($urandom_range(0, 1));
      end
      tick();
    end
    wrEn = 1'b0;
    chk("done_seen", 64'(done_cyc >= 0), 64'(1));
    chk("words_left", 64'(exp_d.size()), 64'(0));
    chk("idle_busy", 64'(busy), 64'(0));
    chk("idle_done", 64'(done), 64'(0));
    inj_cyc = -1;
    stall_first = 0;
  endtask

  initial begin
    int k;
    rst = 1'b0; wrEn = 1'b0; wrAddress = '0; wrData = '0;
    start = 1'b0; count = '0; outReady = 1'b0;
    for (int i = 0; i < 8; i++) model_mem[i] = 32'h0;
    #2;
    chk("rst_valid", 64'(outValid), 64'(0));
    chk("rst_data", 64'(outData), 64'(0));
    chk("rst_last", 64'(outLast), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    tick();
    rst = 1'b1;
    tick();

    // Basic stream, full-rate consumer: valid at +1, +3, +5 samples, done at +6.
    write_word(3'd0, 32'h11);
    write_word(3'd1, 32'h22);
    write_word(3'd2, 32'h33);
    build_exp(3);
    rdy_pct = 100;
    run_stream(3);
    chk("first_latency", 64'(first_vld_cyc), 64'(1));
    chk("done_timing", 64'(done_cyc), 64'(6));

    // Consumer stalls 5 cycles on the first word.
    build_exp(3);
    stall_first = 5;
    run_stream(3);
    chk("stall_vld_samples", 64'(n_vld), 64'(8));
    chk("stall_done_timing", 64'(done_cyc), 64'(11));

    // Empty stream.
    build_exp(0);
    run_stream(0);
    chk("zero_done_timing", 64'(done_cyc), 64'(0));
    chk("zero_no_valid", 64'(n_vld), 64'(0));

    // Write collides with FETCH of entry 1: old value streamed, new value later.
    write_word(3'd1, 32'h5);
    build_exp(2);
    inj_cyc = 2; inj_addr = 3'd1; inj_data = 32'hAA;
    run_stream(2);
    build_exp(2);
    run_stream(2);
    chk("model_aa", 64'(model_mem[1]), 64'(32'hAA));

    // Write to a not-yet-fetched entry is streamed.
    model_mem[2] = 32'hBB;
    build_exp(3);
    inj_cyc = 0; inj_addr = 3'd2; inj_data = 32'hBB;
    run_stream(3);

    // Write to the entry currently in SEND must not disturb outData.
    build_exp(3);
    inj_cyc = 1; inj_addr = 3'd0; inj_data = 32'hCC;
    stall_first = 3;
    run_stream(3);

    // Zero entry in the middle.
    write_word(3'd0, 32'h7);
    write_word(3'd1, 32'h0);
    write_word(3'd2, 32'h9);
    build_exp(3);
    run_stream(3);

    // Reset while the second word of an 8-entry stream is in SEND.
    for (int i = 0; i < 8; i++) write_word(3'(i), $urandom | 32'h1);
    start = 1'b1; count = 4'd8; outReady = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    for (int cyc = 0; cyc < 20 && k < 2; cyc++) begin
      if (outValid) k++;
      if (k < 2) tick();
    end
    chk("reached_second_word", 64'(k), 64'(2));
    rst = 1'b0;
    #1;
    chk("arst_valid", 64'(outValid), 64'(0));
    chk("arst_data", 64'(outData), 64'(0));
    chk("arst_last", 64'(outLast), 64'(0));
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_done", 64'(done), 64'(0));
    for (int i = 0; i < 8; i++) model_mem[i] = 32'h0;
    tick();
    tick();
    chk("arst_no_done", 64'(done), 64'(0));
    rst = 1'b1;
    tick();
    chk("post_rst_done", 64'(done), 64'(0));
    build_exp(2);
    run_stream(2);
    write_word(3'd0, 32'h1234);
    build_exp(1);
    run_stream(1);

    // Random writes and streams with random consumer backpressure.
    for (int it = 0; it < 25; it++) begin
      k = int'($urandom_range(0, 4));
      for (int w = 0; w < k; w++)
        write_word(3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom);
      rdy_pct = int'($urandom_range(30, 100));
      k = int'($urandom_range(0, 8));
      build_exp(k);
      run_stream(k);
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
